bram_arbiter: RTL and testbench
===============================

BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12: byte-address width, matching the bram32 address ports.
REQ-002 Parameter DATA_W, default 32: data word width.
REQ-003 clk  input  1: single clock; all state changes on the rising edge.
REQ-004 rst  input  1: reset, asynchronous, active-low.
REQ-005 if_req  input  1: instruction-fetch read request; held high until if_ack.
REQ-006 if_addr  input  ADDR_W: fetch byte address.
REQ-007 if_ack  output  1: one-cycle pulse; if_rdata valid in this cycle.
REQ-008 if_rdata  output  DATA_W: fetched word.
REQ-009 dm_req  input  1: data-port request; held high until dm_ack.
REQ-010 dm_we  input  1: 1 = write, 0 = read.
REQ-011 dm_addr  input  ADDR_W: data byte address.
REQ-012 dm_wdata  input  DATA_W: write data.
REQ-013 dm_wmask  input  4: byte-lane write mask, bit0 = bits 7:0.
REQ-014 dm_ack  output  1: one-cycle pulse; dm_rdata is valid in this cycle for reads.
REQ-015 dm_rdata  output  DATA_W: read word (0 after a write).
REQ-016 mem_r_addr, mem_w_addr  output  ADDR_W each: BRAM read and write addresses.
REQ-017 mem_r_enb  output  1: BRAM read enable.
REQ-018 mem_w_enb  output  4: BRAM byte write enable.
REQ-019 mem_w_dat  output  DATA_W: BRAM write data.
REQ-020 mem_r_dat  input  DATA_W: BRAM combinational read data.

Function
REQ-021 The FSM SHALL have states IDLE, ACCESS and RESP; the transitions are IDLE->ACCESS when any request is high, ACCESS->RESP always, and RESP->IDLE always.
REQ-022 In IDLE the block SHALL select one requester and latch its address, we, wdata and wmask into internal registers; later changes on that port's inputs SHALL be ignored until its ack.
REQ-023 In ACCESS, a read SHALL drive mem_r_enb=1, mem_r_addr=latched address and mem_w_enb=0; mem_r_dat SHALL be registered at the end of ACCESS.
REQ-024 In ACCESS, a write SHALL drive mem_r_enb=0, mem_w_enb=latched mask, mem_w_addr=latched address and mem_w_dat=latched data.
REQ-025 Outside ACCESS, mem_r_enb=0 and mem_w_enb=0 SHALL hold; mem addresses and mem_w_dat SHALL be 0.
REQ-026 In RESP, the granted port's ack SHALL be 1 for exactly one cycle, with rdata equal to the registered word; the other port's ack SHALL be 0.
REQ-027 Latency SHALL be 2 cycles from the request being sampled in IDLE to the ack, and 3 cycles per transaction; throughput SHALL be at most one access per 3 cycles.
REQ-028 A request arriving during ACCESS or RESP SHALL wait; it is sampled in the next IDLE.
REQ-029 A write with dm_wmask=0000 SHALL still run all states and be acked, with no memory change.
REQ-030 A read's address bits [1:0] SHALL pass through unchanged; word alignment is done by the BRAM.
REQ-031 The block SHALL never assert mem_r_enb together with a non-zero mem_w_enb.

Reset
REQ-032 While rst=0, the outputs SHALL immediately be: state=IDLE, all acks 0, all rdata 0, all mem_* outputs 0, last-grant register = DM.
REQ-033 Reset asserted during ACCESS SHALL drop mem_w_enb to 0 asynchronously, so no write completes.
REQ-034 A reset during a transaction SHALL cancel it without an ack; requesters re-issue after reset.

Configuration
REQ-035 With ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the port not granted last; the last-grant register updates on each grant, so IF wins first after reset.
REQ-036 Without ARB_ROUND_ROBIN_EN, simultaneous requests SHALL always go to DM (fixed priority); the last-grant register is unused.

Verification
REQ-037 Reset, IF read at 0x004 with mem[1]=0x00000013 -> if_ack 2 cycles after sampling, if_rdata=0x00000013.
REQ-038 DM write 0xDEADBEEF, mask 0100, addr 0x010, mem[4]=0 -> mem[4]=0x00AD0000; dm_ack pulses; dm_rdata=0.
REQ-039 IF and DM requests in the same cycle, with the macro off -> DM acked first, then IF 3 cycles later. With the macro on, right after reset -> IF acked first, then DM.
REQ-040 Continuous requests from both ports with the macro on, for 12 cycles -> acks alternate IF, DM, IF, DM; mem_r_enb is never high while mem_w_enb is non-zero.
REQ-041 rst pulsed low during the ACCESS state of a full-mask write -> no ack, target word unchanged, all outputs 0 while rst=0.
REQ-042 DM write with mask 0000 -> dm_ack after 2 cycles, and memory is unchanged.

Source files
------------

// File: rtl/bram_arbiter.sv
// -----------------------------------------------------------------------------
// bram_arbiter
//
// Shares one single-ported-per-direction BRAM between an instruction-fetch
// read port (if_*) and a data port (dm_*). Every transaction takes three
// cycles (IDLE -> ACCESS -> RESP). The ack is a one-cycle pulse in RESP.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : simultaneous requests go to the port not granted last.
//               After reset the last grant is DM, so IF wins first.
//   undefined : simultaneous requests always go to DM (fixed priority).
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous reset, active low
//   if_req       : fetch request, held until if_ack
//   if_addr      : fetch byte address
//   if_ack       : one-cycle pulse, if_rdata valid
//   if_rdata     : fetched word
//   dm_req       : data request, held until dm_ack
//   dm_we        : 1 = write, 0 = read
//   dm_addr      : data byte address
//   dm_wdata     : write data
//   dm_wmask     : byte-lane write mask, bit0 = bits 7:0
//   dm_ack       : one-cycle pulse, dm_rdata valid for reads
//   dm_rdata     : read word (0 after a write)
//   mem_r_addr   : BRAM read address
//   mem_w_addr   : BRAM write address
//   mem_r_enb    : BRAM read enable
//   mem_w_enb    : BRAM byte write enables
//   mem_w_dat    : BRAM write data
//   mem_r_dat    : BRAM combinational read data
// -----------------------------------------------------------------------------
module bram_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [3:0]        dm_wmask,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] mem_r_addr,
    output logic [ADDR_W-1:0] mem_w_addr,
    output logic              mem_r_enb,
    output logic [3:0]        mem_w_enb,
    output logic [DATA_W-1:0] mem_w_dat,
    input  logic [DATA_W-1:0] mem_r_dat
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              w_start;
    logic              w_sel_dm;

    // Latched copy of the granted request; the requester's live inputs are
    // not looked at again until its ack.
    logic              r_gnt_dm;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_wmask;
    logic [DATA_W-1:0] r_rdata;

`ifdef ARB_ROUND_ROBIN_EN
    logic              r_last_dm;
`endif

    assign w_start = if_req | dm_req;

    // Arbitration: pick DM or IF for the request sampled in IDLE.
    always_comb begin
        w_sel_dm = 1'b0;
        if (if_req && dm_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            w_sel_dm = ~r_last_dm;
`else
            w_sel_dm = 1'b1;
`endif
        end else if (dm_req) begin
            w_sel_dm = 1'b1;
        end else begin
            w_sel_dm = 1'b0;
        end
    end

    // Next-state logic: IDLE waits for a request, ACCESS and RESP last one cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next_state = ST_ACCESS;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ACCESS: w_next_state = ST_RESP;
            ST_RESP:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request capture in IDLE; IF is a read-only port so its write fields are zeroed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt_dm <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= {ADDR_W{1'b0}};
            r_wdata  <= {DATA_W{1'b0}};
            r_wmask  <= 4'b0000;
        end else if ((r_state == ST_IDLE) && w_start) begin
            r_gnt_dm <= w_sel_dm;
            if (w_sel_dm) begin
                r_we    <= dm_we;
                r_addr  <= dm_addr;
                r_wdata <= dm_wdata;
                r_wmask <= dm_wmask;
            end else begin
                r_we    <= 1'b0;
                r_addr  <= if_addr;
                r_wdata <= {DATA_W{1'b0}};
                r_wmask <= 4'b0000;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Last-grant tracking; starts at DM so IF is favoured first after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_dm <= 1'b1;
        end else if ((r_state == ST_IDLE) && w_start) begin
            r_last_dm <= w_sel_dm;
        end
    end
`endif

    // Read-data capture at the end of ACCESS; writes return zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= {DATA_W{1'b0}};
        end else if (r_state == ST_ACCESS) begin
            if (r_we) begin
                r_rdata <= {DATA_W{1'b0}};
            end else begin
                r_rdata <= mem_r_dat;
            end
        end
    end

    // Output decode from registered state only. Because r_state resets
    // asynchronously, every enable and ack drops the instant rst goes low.
    always_comb begin
        if_ack     = 1'b0;
        if_rdata   = {DATA_W{1'b0}};
        dm_ack     = 1'b0;
        dm_rdata   = {DATA_W{1'b0}};
        mem_r_addr = {ADDR_W{1'b0}};
        mem_w_addr = {ADDR_W{1'b0}};
        mem_r_enb  = 1'b0;
        mem_w_enb  = 4'b0000;
        mem_w_dat  = {DATA_W{1'b0}};
        case (r_state)
            ST_IDLE: begin
                mem_r_enb = 1'b0;
            end
            ST_ACCESS: begin
                // Read and write enables are mutually exclusive by construction.
                if (r_we) begin
                    mem_w_enb  = r_wmask;
                    mem_w_addr = r_addr;
                    mem_w_dat  = r_wdata;
                end else begin
                    mem_r_enb  = 1'b1;
                    mem_r_addr = r_addr;
                end
            end
            ST_RESP: begin
                if (r_gnt_dm) begin
                    dm_ack   = 1'b1;
                    dm_rdata = r_rdata;
                end else begin
                    if_ack   = 1'b1;
                    if_rdata = r_rdata;
                end
            end
            default: begin
                mem_r_enb = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for bram_arbiter. Directed transactions push their expected ack
// (port + data) into a queue; a monitor on the falling edge pops and compares
// whenever an ack appears. A small behavioural BRAM sits on the mem_* ports.
// -----------------------------------------------------------------------------
module tb_bram_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [11:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [11:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wmask;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic [11:0] mem_r_addr;
    logic [11:0] mem_w_addr;
    logic        mem_r_enb;
    logic [3:0]  mem_w_enb;
    logic [31:0] mem_w_dat;
    logic [31:0] mem_r_dat;

    typedef struct {
        logic        is_dm;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          overlap_cnt = 0;
    logic [11:0] last_raddr = 12'h000;
    logic [31:0] mem [0:1023];

    bram_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_ack     (if_ack),
        .if_rdata   (if_rdata),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_wmask   (dm_wmask),
        .dm_ack     (dm_ack),
        .dm_rdata   (dm_rdata),
        .mem_r_addr (mem_r_addr),
        .mem_w_addr (mem_w_addr),
        .mem_r_enb  (mem_r_enb),
        .mem_w_enb  (mem_w_enb),
        .mem_w_dat  (mem_w_dat),
        .mem_r_dat  (mem_r_dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural BRAM: combinational read, byte-enabled synchronous write.
    assign mem_r_dat = mem[mem_r_addr[11:2]];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_w_enb[b]) mem[mem_w_addr[11:2]][b*8 +: 8] <= mem_w_dat[b*8 +: 8];
        end
    end

    // Monitor: scoreboard compare on every ack, plus enable-overlap watch.
    always @(negedge clk) begin
        exp_t e;
        if (mem_r_enb && (mem_w_enb != 4'b0000)) overlap_cnt++;
        if (mem_r_enb) last_raddr = mem_r_addr;
        if (if_ack && dm_ack) begin
            checks++; failures++;
            $display("FAIL both_acks: if_ack=1 dm_ack=1, required only one");
        end else if (if_ack || dm_ack) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ack: if_ack=%0b dm_ack=%0b, required no ack", if_ack, dm_ack);
            end else begin
                e = sb.pop_front();
                if (e.is_dm != dm_ack || e.data != (dm_ack ? dm_rdata : if_rdata)) begin
                    failures++;
                    $display("FAIL ack_data: got port_dm=%0b data=%08h, required port_dm=%0b data=%08h",
                             dm_ack, (dm_ack ? dm_rdata : if_rdata), e.is_dm, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push(input logic is_dm, input logic [31:0] d);
        exp_t e;
        e.is_dm = is_dm;
        e.data  = d;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic all_outputs_zero();
        return ({if_ack, dm_ack, if_rdata, dm_rdata, mem_r_addr, mem_w_addr,
                 mem_r_enb, mem_w_enb, mem_w_dat} == '0);
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("reset_outputs_zero", {63'd0, all_outputs_zero()}, 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
    endtask

    // Fetch transaction; exp_lat = cycles from request to ack (2 if granted at once).
    task automatic if_txn(input logic [11:0] a, input int exp_lat);
        int n;
        if_addr = a;
        if_req  = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1 && exp_lat == 2) if_addr = ~a;
        end while (!if_ack && n < 20);
        if_req = 1'b0;
        checks++;
        if (!if_ack) begin
            failures++;
            $display("FAIL if_timeout: no if_ack after %0d cycles, required %0d", n, exp_lat);
        end else if (n != exp_lat) begin
            failures++;
            $display("FAIL if_latency: got %0d cycles, required %0d", n, exp_lat);
        end
        tick();
    endtask

    // Data transaction with the same latency bookkeeping.
    task automatic dm_txn(input logic we, input logic [11:0] a, input logic [31:0] d,
                          input logic [3:0] m, input int exp_lat);
        int n;
        dm_we = we; dm_addr = a; dm_wdata = d; dm_wmask = m;
        dm_req = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1 && exp_lat == 2) begin
                dm_we = ~we; dm_addr = ~a; dm_wdata = ~d; dm_wmask = ~m;
            end
        end while (!dm_ack && n < 20);
        dm_req = 1'b0;
        checks++;
        if (!dm_ack) begin
            failures++;
            $display("FAIL dm_timeout: no dm_ack after %0d cycles, required %0d", n, exp_lat);
        end else if (n != exp_lat) begin
            failures++;
            $display("FAIL dm_latency: got %0d cycles, required %0d", n, exp_lat);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[1] = 32'h00000013;
        mem[2] = 32'h22222222;
        mem[5] = 32'h55555555;
        mem[6] = 32'h66666666;
        rst = 1'b0; if_req = 1'b0; if_addr = 12'h000;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 12'h000; dm_wdata = 32'h0; dm_wmask = 4'h0;

        do_reset();

        // Basic fetch.
        push(1'b0, 32'h00000013);
        if_txn(12'h004, 2);

        // Single-lane write, then read it back.
        push(1'b1, 32'h00000000);
        dm_txn(1'b1, 12'h010, 32'hDEADBEEF, 4'b0100, 2);
        check("write_lane2", {32'd0, mem[4]}, {32'd0, 32'h00AD0000});
        push(1'b1, 32'h00AD0000);
        dm_txn(1'b0, 12'h010, 32'h0, 4'b0000, 2);

        // Unaligned fetch address passes through to the BRAM untouched.
        push(1'b0, 32'h00000013);
        if_txn(12'h007, 2);
        check("raddr_passthrough", {52'd0, last_raddr}, {52'd0, 12'h007});

        // Empty-mask write still acks, memory unchanged.
        push(1'b1, 32'h00000000);
        dm_txn(1'b1, 12'h014, 32'hFFFFFFFF, 4'b0000, 2);
        check("mask0_no_change", {32'd0, mem[5]}, {32'd0, 32'h55555555});

        // Reset in the middle of ACCESS of a full-mask write: no ack, no write.
        dm_we = 1'b1; dm_addr = 12'h018; dm_wdata = 32'h12345678; dm_wmask = 4'hF;
        dm_req = 1'b1;
        tick();
        check("access_wenb", {60'd0, mem_w_enb}, {60'd0, 4'hF});
        #2;
        rst = 1'b0;
        #1;
        check("midreset_outputs_zero", {63'd0, all_outputs_zero()}, 64'd1);
        dm_req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midreset_no_write", {32'd0, mem[6]}, {32'd0, 32'h66666666});

        // Simultaneous requests right after a reset.
        do_reset();
`ifdef ARB_ROUND_ROBIN_EN
        push(1'b0, 32'h00000013);
        push(1'b1, 32'h22222222);
        fork
            if_txn(12'h004, 2);
            dm_txn(1'b0, 12'h008, 32'h0, 4'b0000, 5);
        join
`else
        push(1'b1, 32'h22222222);
        push(1'b0, 32'h00000013);
        fork
            if_txn(12'h004, 5);
            dm_txn(1'b0, 12'h008, 32'h0, 4'b0000, 2);
        join
`endif

        // Both ports requesting continuously for 12 cycles.
        do_reset();
`ifdef ARB_ROUND_ROBIN_EN
        push(1'b0, 32'h00000013);
        push(1'b1, 32'h22222222);
        push(1'b0, 32'h00000013);
        push(1'b1, 32'h22222222);
`else
        for (int k = 0; k < 4; k++) push(1'b1, 32'h22222222);
`endif
        if_addr = 12'h004;
        dm_we = 1'b0; dm_addr = 12'h008; dm_wdata = 32'h0; dm_wmask = 4'h0;
        if_req = 1'b1;
        dm_req = 1'b1;
        repeat (12) tick();
        if_req = 1'b0;
        dm_req = 1'b0;
        repeat (3) tick();

        check("scoreboard_drained", {32'd0, 32'(sb.size())}, 64'd0);
        check("no_enable_overlap", {32'd0, 32'(overlap_cnt)}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
